// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM encodings,
// parity selection values and the default baud prescale.
package fifo_uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEFAULT_PRESCALE = 16;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..PRESCALE-1 and flags the last cycle of each
// serial bit with tick_o. A synchronous clear holds it at zero while idle.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(PRESCALE - 1));

    // Next count: restart on clear or after the terminal cycle, never wraps past it.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter. Pops one word per frame from a
// first-word-fall-through FIFO and sends start, data LSB-first, optional
// parity and stop bits. A pop on the last STOP cycle chains the next frame
// with no idle gap.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// START  | start bit (0)
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit of the latched word (only if latched PAR_EN)
// STOP   | stop bit (1); may pop the next word on its last cycle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = DEFAULT_PRESCALE
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [BW-1:0]         bit_cnt_d;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  tx_d;
    logic                  busy_q;
    logic                  tick;
    logic                  pop;

    baud_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_baud (
        .clk_i (R_CLK),
        .rst_i (R_RST),
        .clr_i (state_q == ST_IDLE),
        .tick_o(tick)
    );

    // Reset is gated in so no pop is requested while the block is held in reset.
    assign pop = !R_RST && !EMPTY &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));

    assign R_INC  = pop;
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    // Next state, bit index and line level for the coming cycle.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d   = pop ? ST_START : ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[bit_cnt_d];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
    end

    // FSM, frame registers and registered line/busy outputs.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != ST_IDLE);
            if (pop) begin
                data_q    <= RD_DATA;
                par_en_q  <= PAR_EN;
                par_bit_q <= (^RD_DATA) ^ (PAR_TYP == PAR_ODD);
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int PRE = 16;

    logic          R_CLK   = 1'b0;
    logic          R_RST   = 1'b1;
    logic          EMPTY   = 1'b1;
    logic [DW-1:0] RD_DATA = '0;
    logic          PAR_EN  = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          R_INC;
    logic          TX_OUT;
    logic          BUSY;

    fifo_uart_tx #(.DATA_WIDTH(DW), .PRESCALE(PRE)) dut (
        .R_CLK  (R_CLK),
        .R_RST  (R_RST),
        .EMPTY  (EMPTY),
        .RD_DATA(RD_DATA),
        .PAR_EN (PAR_EN),
        .PAR_TYP(PAR_TYP),
        .R_INC  (R_INC),
        .TX_OUT (TX_OUT),
        .BUSY   (BUSY)
    );

    always #5 R_CLK = ~R_CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // bench FIFO: stimulus writes mem/wr_ptr, model process owns rd_ptr
    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    // expected line level per cycle for the frames in flight
    bit            line_q[$];
    int            pop_cyc[$];
    int            cyc      = 0;
    int            pop_cnt  = 0;
    int            busy_cyc = 0;
    logic [DW-1:0] last_word = '0;
    bit            prev_pop = 0;
    bit            prev_en  = 0;
    bit            prev_typ = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void add_bit(input bit b);
        repeat (PRE) line_q.push_back(b);
    endfunction

    // Model: FIFO behaviour plus expected serial waveform, checked every cycle.
    always @(negedge R_CLK) begin : model
        bit            exp_tx;
        bit            exp_busy;
        bit            exp_inc;
        logic [DW-1:0] w;
        cyc++;
        if (R_RST) begin
            line_q.delete();
            prev_pop = 0;
        end else begin
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (prev_pop && (wr_ptr != rd_ptr)) begin
                w = mem[rd_ptr % 256];
                rd_ptr++;
                last_word = w;
                pop_cnt++;
                pop_cyc.push_back(cyc);
                add_bit(1'b0);
                for (int i = 0; i < DW; i++) add_bit(w[i]);
                if (prev_en) add_bit((^w) ^ prev_typ);
                add_bit(1'b1);
            end
        end
        EMPTY   = (wr_ptr == rd_ptr);
        RD_DATA = EMPTY ? '0 : mem[rd_ptr % 256];
        exp_tx   = (line_q.size() != 0) ? line_q[0] : 1'b1;
        exp_busy = (line_q.size() != 0);
        exp_inc  = !R_RST && !EMPTY && (line_q.size() <= 1);
        #1;
        chk("tx_out", {31'd0, TX_OUT}, {31'd0, exp_tx});
        chk("busy",   {31'd0, BUSY},   {31'd0, exp_busy});
        chk("r_inc",  {31'd0, R_INC},  {31'd0, exp_inc});
        if (BUSY) busy_cyc++;
        prev_pop = R_INC;
        prev_en  = PAR_EN;
        prev_typ = PAR_TYP;
    end

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    task automatic wait_pop(input string name, input int budget);
        int  start = pop_cnt;
        bit  seen  = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge R_CLK); #2;
            if (pop_cnt != start) seen = 1;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no pop within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge R_CLK); #2;
            if (!BUSY && EMPTY && line_q.size() == 0) done = 1;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s: not idle within %0d cycles", name, budget);
        end
    endtask

    // advance from frame-relative cycle cur to target (sampling at negedge+2)
    task automatic advance(input int target, inout int cur);
        repeat (target - cur) @(negedge R_CLK);
        #2;
        cur = target;
    endtask

    task automatic at_posedge();
        @(posedge R_CLK); #2;
    endtask

    initial begin
        int a5_bits[10];
        int cur;
        int p0;
        int b0;
        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // 1. reset held with data waiting
        at_posedge();
        push(8'h11);
        repeat (5) at_posedge();
        chk("rst_tx",   {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, BUSY},   32'd0);
        chk("rst_rinc", {31'd0, R_INC},  32'd0);
        chk("rst_nopop", pop_cnt, 32'd0);
        R_RST = 1'b0;
        wait_pop("rst_release_pop", 10);
        chk("rst_word", {24'd0, last_word}, 32'h11);
        wait_idle("rst_drain", 400);

        // 2. single word 0xA5, no parity
        at_posedge();
        p0 = pop_cnt; b0 = busy_cyc;
        push(8'hA5);
        wait_pop("a5_pop", 10);
        cur = 0;
        for (int b = 0; b < 10; b++) begin
            advance(PRE * b + 8, cur);
            chk($sformatf("a5_bit%0d", b), {31'd0, TX_OUT}, a5_bits[b]);
        end
        wait_idle("a5_idle", 400);
        chk("a5_pops", pop_cnt - p0, 32'd1);
        chk("a5_busy_len", busy_cyc - b0, 32'd160);

        // 3a. even parity, 0x07
        at_posedge();
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        b0 = busy_cyc;
        push(8'h07);
        wait_pop("even_pop", 10);
        cur = 0;
        advance(PRE * 9 + 8, cur);
        chk("even_par", {31'd0, TX_OUT}, 32'd1);
        wait_idle("even_idle", 400);
        chk("even_busy_len", busy_cyc - b0, 32'd176);

        // 3b. odd parity, 0x07
        at_posedge();
        PAR_TYP = 1'b1;
        push(8'h07);
        wait_pop("odd_pop", 10);
        cur = 0;
        advance(PRE * 9 + 8, cur);
        chk("odd_par", {31'd0, TX_OUT}, 32'd0);
        wait_idle("odd_idle", 400);

        // 3c. PAR_TYP flipped mid-frame must not affect the frame
        at_posedge();
        PAR_TYP = 1'b0;
        push(8'h07);
        wait_pop("toggle_pop", 10);
        cur = 0;
        advance(50, cur);
        PAR_TYP = 1'b1;
        advance(PRE * 9 + 8, cur);
        chk("toggle_par", {31'd0, TX_OUT}, 32'd1);
        wait_idle("toggle_idle", 400);
        at_posedge();
        PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // 4. back-to-back 0x01, 0x02, 0x03
        at_posedge();
        p0 = pop_cnt; b0 = busy_cyc;
        push(8'h01); push(8'h02); push(8'h03);
        wait_pop("b2b_pop", 10);
        wait_idle("b2b_idle", 700);
        chk("b2b_pops", pop_cnt - p0, 32'd3);
        if (pop_cyc.size() >= 3) begin
            chk("b2b_gap1", pop_cyc[pop_cyc.size()-2] - pop_cyc[pop_cyc.size()-3], 32'd160);
            chk("b2b_gap2", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 32'd160);
        end
        chk("b2b_busy_len", busy_cyc - b0, 32'd480);
        chk("b2b_empty", {31'd0, EMPTY}, 32'd1);
        chk("b2b_last", {24'd0, last_word}, 32'h03);

        // 5. empty for 100 cycles, then late data
        p0 = pop_cnt;
        repeat (100) at_posedge();
        chk("empty_nopop", pop_cnt - p0, 32'd0);
        chk("empty_tx", {31'd0, TX_OUT}, 32'd1);
        push(8'h3C);
        wait_pop("late_pop", 10);
        chk("late_start", {31'd0, TX_OUT}, 32'd0);
        chk("late_busy",  {31'd0, BUSY},   32'd1);
        wait_idle("late_idle", 400);

        // 6. reset during DATA bit 3 of 0x5A
        at_posedge();
        p0 = pop_cnt;
        push(8'h5A); push(8'h66);
        wait_pop("mid_pop", 10);
        cur = 0;
        advance(PRE * 4 + 8, cur);
        chk("mid_bit3", {31'd0, TX_OUT}, 32'd1);
        chk("mid_busy_pre", {31'd0, BUSY}, 32'd1);
        R_RST = 1'b1;
        #1;
        chk("mid_rst_tx",   {31'd0, TX_OUT}, 32'd1);
        chk("mid_rst_busy", {31'd0, BUSY},   32'd0);
        chk("mid_rst_rinc", {31'd0, R_INC},  32'd0);
        repeat (3) at_posedge();
        R_RST = 1'b0;
        wait_pop("mid_next_pop", 10);
        chk("mid_next_word", {24'd0, last_word}, 32'h66);
        wait_idle("mid_idle", 400);
        chk("mid_pops", pop_cnt - p0, 32'd2);

        repeat (5) at_posedge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
